// File: rtl/serial_addsub_seq.sv
// serial_addsub_seq: word-serial add/subtract sequencer.
// One shared WIDTH-bit adder slice (invert-on-subtract plus a ripple-carry chain) processes a
// WIDTH*WORDS-bit operation one slice per cycle, LSB slice first, through a registered carry.
//
// Ports:
//   CLK     rising-edge clock
//   RESETN  asynchronous active-low reset
//   START   request pulse, sampled only in IDLE
//   SUB     0 = A+B, 1 = A-B, captured with the operands
//   A, B    N-bit operands, captured when START is accepted
//   BUSY    high in RUN and DONE
//   DONE    one-cycle pulse, result valid
//   O       N-bit result, holds until the next DONE
//   COUT    final carry; for subtraction 1 = no borrow (A >= B)
//   OVF     signed overflow (present only when SERIAL_ADDSUB_OVF_EN is defined)
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN
module serial_addsub_seq #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned WORDS = 4
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     START,
    input  logic                     SUB,
    input  logic [WIDTH*WORDS-1:0]   A,
    input  logic [WIDTH*WORDS-1:0]   B,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [WIDTH*WORDS-1:0]   O,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic                     COUT,
    output logic                     OVF
`else
    output logic                     COUT
`endif
);

    localparam int unsigned N    = WIDTH * WORDS;
    localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      a_q, a_d, b_q, b_d;
    logic              sub_q, sub_d;
    logic              carry_q, carry_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [N-1:0]      res_q, res_d;
    logic [N-1:0]      o_q, o_d;
    logic              cout_q, cout_d;

    logic [WIDTH-1:0]  slice_a, slice_b, slice_sum;
    logic              slice_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic              ovf_q, ovf_d;
    logic              slice_msb_cin;
`endif

    // Shared adder slice: operand B inverted for subtraction, carry-in seeded with SUB on accept.
    always_comb begin
        logic c;
        slice_a   = a_q[idx_q*WIDTH +: WIDTH];
        slice_b   = b_q[idx_q*WIDTH +: WIDTH] ^ {WIDTH{sub_q}};
        slice_sum = '0;
        c         = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        slice_msb_cin = 1'b0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
`ifdef SERIAL_ADDSUB_OVF_EN
            if (i == WIDTH - 1) slice_msb_cin = c;
`endif
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ c;
            c = (slice_a[i] & slice_b[i]) | (slice_a[i] & c) | (slice_b[i] & c);
        end
        slice_cout = c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        res_d   = res_q;
        o_d     = o_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = SUB;
                    carry_d = SUB;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                res_d[idx_q*WIDTH +: WIDTH] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LastIdx) begin
                    // res_d already holds the final slice here.
                    o_d     = res_d;
                    cout_d  = slice_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
                    ovf_d   = slice_msb_cin ^ slice_cout;
`endif
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            res_q   <= '0;
            o_q     <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            o_q     <= o_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign BUSY = (state_q != StIdle);
    assign DONE = (state_q == StDone);
    assign O    = o_q;
    assign COUT = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule
